// File: rtl/sysid_chk_pkg.sv
// Shared types and constants for the system-ID boot checker.
// SYSID_CHECK_TS_EN adds the timestamp read/compare phase.
package sysid_chk_pkg;

  localparam logic ADDR_ID   = 1'b0;
  localparam logic ADDR_TS   = 1'b1;
  localparam int   ATTEMPT_W = 4;
  localparam int   GAP_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID,
`ifdef SYSID_CHECK_TS_EN
    ST_RD_TS,
`endif
    ST_COMPARE,
    ST_GAP,
    ST_DONE
  } state_e;

  // Timestamp only participates when use_ts is set.
  function automatic logic words_match(logic [31:0] id, logic [31:0] ts,
                                       logic [31:0] exp_id, logic [31:0] exp_ts,
                                       logic use_ts);
    return (id == exp_id) && (!use_ts || (ts == exp_ts));
  endfunction

endpackage

// File: rtl/sysid_boot_checker_if.sv
// Avalon-MM read path between the boot checker and the system-ID slave.
interface sysid_boot_checker_if;
  logic        sysid_address;
  logic        sysid_read;
  logic [31:0] sysid_readdata;

  modport master (output sysid_address, output sysid_read, input sysid_readdata);
  modport slave  (input sysid_address, input sysid_read, output sysid_readdata);
endinterface

// File: rtl/sysid_boot_checker.sv
// Reads the system-ID words, compares against build-time values, retries on mismatch.
// SYSID_CHECK_TS_EN defined: timestamp word (address 1) is read and compared too.
module sysid_boot_checker
  import sysid_chk_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID  = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS  = 32'h58F9_2A21,
  parameter int          READ_LATENCY = 0,
  parameter int          MAX_RETRIES  = 3,
  parameter int          RETRY_GAP    = 16
)(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  sysid_boot_checker_if.master bus,
  output logic [31:0]          id_value,
  output logic [31:0]          ts_value,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic [ATTEMPT_W-1:0] attempts
);

  localparam logic [GAP_W-1:0]     LAT_LD = GAP_W'(READ_LATENCY);
  localparam logic [GAP_W-1:0]     GAP_LD = GAP_W'(RETRY_GAP - 1);
  localparam logic [ATTEMPT_W-1:0] MAX_RT = ATTEMPT_W'(MAX_RETRIES);

  state_e               state_q, state_d;
  logic [GAP_W-1:0]     cnt_q, cnt_d;
  logic [31:0]          id_q, id_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 fail_q, fail_d;
  logic [ATTEMPT_W-1:0] att_q, att_d;
  logic                 match;

`ifdef SYSID_CHECK_TS_EN
  logic [31:0] ts_q, ts_d;
  assign match    = words_match(id_q, ts_q, EXPECTED_ID, EXPECTED_TS, 1'b1);
  assign ts_value = ts_q;
`else
  assign match    = words_match(id_q, 32'h0, EXPECTED_ID, EXPECTED_TS, 1'b0);
  assign ts_value = '0;
`endif

  // cnt_q is shared: read-latency countdown in read states, idle countdown in GAP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    att_d   = att_q;
`ifdef SYSID_CHECK_TS_EN
    ts_d    = ts_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RD_ID;
          cnt_d   = LAT_LD;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          att_d   = ATTEMPT_W'(1);
          busy_d  = 1'b1;
        end
      end
      ST_RD_ID: begin
        if (cnt_q == '0) begin
          id_d = bus.sysid_readdata;
`ifdef SYSID_CHECK_TS_EN
          state_d = ST_RD_TS;
          cnt_d   = LAT_LD;
`else
          state_d = ST_COMPARE;
`endif
        end else begin
          cnt_d = cnt_q - GAP_W'(1);
        end
      end
`ifdef SYSID_CHECK_TS_EN
      ST_RD_TS: begin
        if (cnt_q == '0) begin
          ts_d    = bus.sysid_readdata;
          state_d = ST_COMPARE;
        end else begin
          cnt_d = cnt_q - GAP_W'(1);
        end
      end
`endif
      ST_COMPARE: begin
        if (match) begin
          state_d = ST_DONE;
          pass_d  = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (att_q <= MAX_RT) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LD;
        end else begin
          state_d = ST_DONE;
          fail_d  = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_RD_ID;
          cnt_d   = LAT_LD;
          att_d   = att_q + ATTEMPT_W'(1);
        end else begin
          cnt_d = cnt_q - GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      id_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      att_q   <= '0;
`ifdef SYSID_CHECK_TS_EN
      ts_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      att_q   <= att_d;
`ifdef SYSID_CHECK_TS_EN
      ts_q    <= ts_d;
`endif
    end
  end

  // Bus strobes decode straight from the state register.
  assign bus.sysid_read    = (state_q == ST_RD_ID)
`ifdef SYSID_CHECK_TS_EN
                           || (state_q == ST_RD_TS)
`endif
                           ;
`ifdef SYSID_CHECK_TS_EN
  assign bus.sysid_address = (state_q == ST_RD_TS) ? ADDR_TS : ADDR_ID;
`else
  assign bus.sysid_address = ADDR_ID;
`endif

  assign id_value = id_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign attempts = att_q;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Randomized bench: two checker instances (latency 0 and 2) against a behavioural slave and result model.
module tb_sysid_boot_checker;
  import sysid_chk_pkg::*;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'h58F9_2A21;
  localparam int LAT_A = 0, MAXR_A = 3, GAP_A = 16;
  localparam int LAT_B = 2, MAXR_B = 1, GAP_B = 3;
`ifdef SYSID_CHECK_TS_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  function automatic int lat_of(int u);  return (u == 0) ? LAT_A  : LAT_B;  endfunction
  function automatic int maxr_of(int u); return (u == 0) ? MAXR_A : MAXR_B; endfunction
  function automatic int gap_of(int u);  return (u == 0) ? GAP_A  : GAP_B;  endfunction

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic        start_s[2];
  logic        slv_clr[2];
  logic        busy_o[2], done_o[2], pass_o[2], fail_o[2];
  logic [31:0] idv_o[2], tsv_o[2];
  logic [3:0]  att_o[2];
  logic        rd_s[2], addr_s[2];
  logic [31:0] rdata_s[2];

  sysid_boot_checker_if bus_a();
  sysid_boot_checker_if bus_b();

  assign rd_s[0] = bus_a.sysid_read;
  assign addr_s[0] = bus_a.sysid_address;
  assign bus_a.sysid_readdata = rdata_s[0];
  assign rd_s[1] = bus_b.sysid_read;
  assign addr_s[1] = bus_b.sysid_address;
  assign bus_b.sysid_readdata = rdata_s[1];

  sysid_boot_checker #(.EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(LAT_A),
                       .MAX_RETRIES(MAXR_A), .RETRY_GAP(GAP_A)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_s[0]), .bus(bus_a),
    .id_value(idv_o[0]), .ts_value(tsv_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .pass(pass_o[0]), .fail(fail_o[0]), .attempts(att_o[0]));

  sysid_boot_checker #(.EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(LAT_B),
                       .MAX_RETRIES(MAXR_B), .RETRY_GAP(GAP_B)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_s[1]), .bus(bus_b),
    .id_value(idv_o[1]), .ts_value(tsv_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .pass(pass_o[1]), .fail(fail_o[1]), .attempts(att_o[1]));

  // Slave: per-attempt response tables; valid data only on the final cycle of a read phase.
  logic [31:0] id_resp[2][16];
  logic [31:0] ts_resp[2][16];
  int          run_q[2], att_q[2], cur_run[2], cur_att[2];
  logic        prev_rd[2], prev_addr[2];
  logic [31:0] junk_q[2];

  always_comb begin
    for (int u = 0; u < 2; u++) begin
      int idx;
      cur_run[u] = (rd_s[u] && prev_rd[u] && (prev_addr[u] == addr_s[u])) ? run_q[u] + 1 : 0;
      cur_att[u] = (rd_s[u] && !addr_s[u] && cur_run[u] == 0) ? att_q[u] + 1 : att_q[u];
      idx = cur_att[u] - 1;
      if (idx < 0) idx = 0;
      if (idx > 15) idx = 15;
      rdata_s[u] = junk_q[u];
      if (rd_s[u] && cur_run[u] == lat_of(u))
        rdata_s[u] = addr_s[u] ? ts_resp[u][idx] : id_resp[u][idx];
    end
  end

  always @(posedge clock) begin
    for (int u = 0; u < 2; u++) begin
      if (!reset_n || slv_clr[u]) begin
        run_q[u] <= 0; att_q[u] <= 0; prev_rd[u] <= 1'b0; prev_addr[u] <= 1'b0;
      end else begin
        run_q[u] <= cur_run[u]; att_q[u] <= cur_att[u];
        prev_rd[u] <= rd_s[u]; prev_addr[u] <= addr_s[u];
      end
      junk_q[u] <= $urandom;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_resp(input int u, input int n_bad, input bit ts_only);
    for (int i = 0; i < 16; i++) begin
      id_resp[u][i] = EXP_ID;
      ts_resp[u][i] = EXP_TS;
      if (i < n_bad) begin
        if (ts_only || $urandom_range(0, 1) == 1) ts_resp[u][i] = EXP_TS ^ ($urandom | 32'h1);
        else                                     id_resp[u][i] = EXP_ID ^ ($urandom | 32'h1);
      end
    end
  endtask

  task automatic set_all(input int u, input logic [31:0] v);
    for (int i = 0; i < 16; i++) begin
      id_resp[u][i] = v;
      ts_resp[u][i] = v;
    end
  endtask

  // Reference: first matching attempt wins; latency from per-attempt cost plus gaps.
  task automatic model(input int u, output int e_att, output bit e_pass,
                       output logic [31:0] e_id, output logic [31:0] e_ts,
                       output int e_lat, output int e_rd, output int e_hi);
    int nreads, maxa;
    bit found;
    nreads = TS_EN ? 2 : 1;
    maxa   = maxr_of(u) + 1;
    found  = 1'b0;
    e_att  = maxa;
    for (int k = 1; k <= maxa; k++) begin
      if (!found && id_resp[u][k-1] == EXP_ID && (!TS_EN || ts_resp[u][k-1] == EXP_TS)) begin
        found = 1'b1;
        e_att = k;
      end
    end
    e_pass = found;
    e_lat  = e_att * (nreads * (lat_of(u) + 1) + 1) + (e_att - 1) * gap_of(u);
    e_rd   = e_att * nreads * (lat_of(u) + 1);
    e_hi   = TS_EN ? e_att * (lat_of(u) + 1) : 0;
    e_id   = id_resp[u][e_att-1];
    e_ts   = TS_EN ? ts_resp[u][e_att-1] : 32'h0;
  endtask

  task automatic run_check(input int u, input int restart_at, input string tag);
    int e_att, e_lat, e_rd, e_hi, cyc, rdc, hic, busyc, ovl;
    bit e_pass;
    logic [31:0] e_id, e_ts;
    model(u, e_att, e_pass, e_id, e_ts, e_lat, e_rd, e_hi);
    @(negedge clock);
    start_s[u] = 1'b1; slv_clr[u] = 1'b1;
    @(posedge clock); #1;
    start_s[u] = 1'b0; slv_clr[u] = 1'b0;
    cyc = 0; rdc = 0; hic = 0; busyc = 0; ovl = 0;
    while (1) begin
      rdc   += int'(rd_s[u]);
      hic   += int'(addr_s[u]);
      busyc += int'(busy_o[u]);
      if (busy_o[u] && done_o[u]) ovl++;
      if (done_o[u] || cyc >= 3000) break;
      @(posedge clock); #1;
      cyc++;
      start_s[u] = (cyc == restart_at);
    end
    start_s[u] = 1'b0;
    chk({tag, "_done"},     32'(done_o[u]), 32'd1);
    chk({tag, "_latency"},  32'(cyc), 32'(e_lat));
    chk({tag, "_pass"},     32'(pass_o[u]), 32'(e_pass));
    chk({tag, "_fail"},     32'(fail_o[u]), 32'(!e_pass));
    chk({tag, "_attempts"}, 32'(att_o[u]), 32'(e_att));
    chk({tag, "_id"},       idv_o[u], e_id);
    chk({tag, "_ts"},       tsv_o[u], e_ts);
    chk({tag, "_rdcycles"}, 32'(rdc), 32'(e_rd));
    chk({tag, "_addr1cyc"}, 32'(hic), 32'(e_hi));
    chk({tag, "_busycyc"},  32'(busyc), 32'(e_lat));
    chk({tag, "_overlap"},  32'(ovl), 32'd0);
    @(posedge clock); #1;
    chk({tag, "_hold"}, {30'd0, done_o[u], pass_o[u]}, {30'd0, 1'b1, e_pass});
  endtask

  task automatic check_zero(input int u, input string tag);
    chk({tag, "_busy"}, 32'(busy_o[u]), 32'd0);
    chk({tag, "_done"}, 32'(done_o[u]), 32'd0);
    chk({tag, "_pf"},   {30'd0, pass_o[u], fail_o[u]}, 32'd0);
    chk({tag, "_att"},  32'(att_o[u]), 32'd0);
    chk({tag, "_id"},   idv_o[u], 32'd0);
    chk({tag, "_ts"},   tsv_o[u], 32'd0);
    chk({tag, "_bus"},  {30'd0, rd_s[u], addr_s[u]}, 32'd0);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      start_s[u] = 1'b0; slv_clr[u] = 1'b0;
      set_resp(u, 0, 1'b0);
    end
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_zero(0, "rst_a");
    check_zero(1, "rst_b");
    @(negedge clock) reset_n = 1'b1;

    set_resp(0, 0, 1'b0); run_check(0, -1, "good_l0");
    set_resp(0, 2, 1'b0);
    for (int i = 0; i < 2; i++) id_resp[0][i] = 32'h1234_0000 + i;
    run_check(0, -1, "two_bad");
    set_all(0, 32'hDEAD_BEEF); run_check(0, -1, "deadbeef");
    set_resp(1, 0, 1'b0); run_check(1, -1, "good_l2");
    set_resp(1, 0, 1'b0); run_check(1, 2, "restart");
    set_resp(0, 1, 1'b1); run_check(0, -1, "bad_ts");

    // Reset in the middle of a read phase drops everything.
    set_resp(1, 0, 1'b0);
    @(negedge clock); start_s[1] = 1'b1; slv_clr[1] = 1'b1;
    @(posedge clock); #1; start_s[1] = 1'b0; slv_clr[1] = 1'b0;
    @(posedge clock); #1;
    chk("midrst_reading", 32'(rd_s[1]), 32'd1);
    @(negedge clock) reset_n = 1'b0;
    @(posedge clock); #1;
    check_zero(0, "midrst_a");
    check_zero(1, "midrst_b");
    @(negedge clock) reset_n = 1'b1;
    run_check(1, -1, "after_rst");

    for (int t = 0; t < 20; t++) begin
      int u;
      u = $urandom_range(0, 1);
      set_resp(u, $urandom_range(0, maxr_of(u) + 2), 1'b0);
      run_check(u, -1, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
